// File: rtl/enc_pkg.sv
// Shared encoder types and helpers for prio_event_encoder and future encoder variants.
// The optional round-robin build is selected with PRIO_EVENT_ENCODER_RR_EN.
package enc_pkg;

  localparam int ENC_MAX_IDX_W = 16;

  function automatic int clog2_f(input int value);
    int result;
    int v;
    result = 32'sd0;
    v = value - 32'sd1;
    while (v > 32'sd0) begin
      result = result + 32'sd1;
      v = v >>> 1;
    end
    return result;
  endfunction

  // Sized for the widest supported encoder; narrower users take the low IDX_W bits.
  typedef struct packed {
    logic                     found;
    logic [ENC_MAX_IDX_W-1:0] idx;
  } enc_sel_t;

endpackage

// File: rtl/prio_event_encoder_if.sv
// Valid/ready index channel between prio_event_encoder (master) and its consumer (slave).
// Identical in the fixed and PRIO_EVENT_ENCODER_RR_EN builds.
interface prio_event_encoder_if
  import enc_pkg::*;
#(
  parameter int N = 4
);
  localparam int IDX_W = clog2_f(N);

  logic             out_valid_o;
  logic             out_ready_i;
  logic [IDX_W-1:0] out_idx_o;

  modport master (output out_valid_o, output out_idx_o, input out_ready_i);
  modport slave  (input out_valid_o, input out_idx_o, output out_ready_i);
endinterface

// File: rtl/prio_pick.sv
// Combinational priority pick: first set bit of vec at or after start_ptr, wrapping at N-1.
// Shared by the fixed (start_ptr = 0) and PRIO_EVENT_ENCODER_RR_EN builds.
module prio_pick
  import enc_pkg::*;
#(
  parameter  int N     = 4,
  localparam int IDX_W = clog2_f(N)
) (
  input  logic [N-1:0]     vec,
  input  logic [IDX_W-1:0] start_ptr,
  output enc_sel_t         sel
);

  logic [2*N-1:0]   dbl_s;
  logic [N-1:0]     rot_s;
  logic             found_s;
  logic [IDX_W-1:0] off_s;
  logic [IDX_W:0]   sum_s;
  logic [IDX_W:0]   wrap_s;

  // Rotate so start_ptr lands at bit 0, pick the lowest set bit, then map back to an index.
  always_comb begin
    dbl_s   = {vec, vec};
    rot_s   = dbl_s[{1'b0, start_ptr} +: N];
    found_s = 1'b0;
    off_s   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      found_s = found_s | rot_s[k];
      off_s   = rot_s[k] ? IDX_W'(k) : off_s;
    end
    sum_s  = {1'b0, start_ptr} + {1'b0, off_s};
    wrap_s = (sum_s >= (IDX_W+1)'(N)) ? (sum_s - (IDX_W+1)'(N)) : sum_s;
    sel                = '0;
    sel.found          = found_s;
    sel.idx[IDX_W-1:0] = wrap_s[IDX_W-1:0];
  end

endmodule

// File: rtl/prio_event_encoder.sv
// Sticky-pending event encoder: serialises request lines into one index per valid/ready transfer.
// Define PRIO_EVENT_ENCODER_RR_EN for round-robin selection; default is fixed lowest-index priority.
module prio_event_encoder
  import enc_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_i,
  output logic [N-1:0]         pending_o,
  output logic                 busy_o,
  output logic                 coalesce_o,
  prio_event_encoder_if.master out_if
);

  localparam int IDX_W = clog2_f(N);

  logic [N-1:0]     pending_r;
  logic             out_valid_r;
  logic [IDX_W-1:0] out_idx_r;
  logic             coalesce_r;
  logic [IDX_W-1:0] start_s;
  enc_sel_t         sel_s;
  logic             load_s;
  logic [N-1:0]     load_mask_s;
  logic             unused_sel_s;

`ifdef PRIO_EVENT_ENCODER_RR_EN
  logic [IDX_W-1:0] rr_ptr_r;

  // Search begins just past the last issued index.
  always_comb begin
    if (rr_ptr_r == IDX_W'(N - 1)) begin
      start_s = '0;
    end else begin
      start_s = rr_ptr_r + IDX_W'(1);
    end
  end

  // Remember the last issued index; N-1 after reset so the first search starts at 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_r <= IDX_W'(N - 1);
    end else if (load_s) begin
      rr_ptr_r <= sel_s.idx[IDX_W-1:0];
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end
`else
  assign start_s = '0;
`endif

  prio_pick #(.N(N)) u_pick (
    .vec       (pending_r),
    .start_ptr (start_s),
    .sel       (sel_s)
  );

  assign load_s       = (!out_valid_r || out_if.out_ready_i) && (pending_r != '0);
  assign unused_sel_s = sel_s.found ^ (^sel_s.idx[ENC_MAX_IDX_W-1:IDX_W]);

  // One-hot of the bit being handed to the output slot this cycle.
  always_comb begin
    load_mask_s = '0;
    if (load_s) begin
      load_mask_s[sel_s.idx[IDX_W-1:0]] = 1'b1;
    end else begin
      load_mask_s = '0;
    end
  end

  // Pending, output slot and coalesce state; a fresh request outranks the clear on load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_r   <= '0;
      out_valid_r <= 1'b0;
      out_idx_r   <= '0;
      coalesce_r  <= 1'b0;
    end else begin
      pending_r  <= (pending_r & ~load_mask_s) | req_i;
      coalesce_r <= |(req_i & pending_r & ~load_mask_s);
      if (load_s) begin
        out_valid_r <= 1'b1;
        out_idx_r   <= sel_s.idx[IDX_W-1:0];
      end else if (out_valid_r && out_if.out_ready_i) begin
        out_valid_r <= 1'b0;
        out_idx_r   <= '0;
      end else begin
        out_valid_r <= out_valid_r;
        out_idx_r   <= out_idx_r;
      end
    end
  end

  assign out_if.out_valid_o = out_valid_r;
  assign out_if.out_idx_o   = out_idx_r;
  assign pending_o          = pending_r;
  assign coalesce_o         = coalesce_r;
  assign busy_o             = (|pending_r) | out_valid_r;

endmodule
